// File: rtl/fetch_pkg.sv
// Shared fetch/core constants and the sequential-PC helper.
// Pure declarations, no timing.
// No flow control of its own.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  // PC_LIMIT is shared with the core; keep this the only definition.
  localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_LIMIT = 32'h0000_03FC;

  // Sequential successor of a fetch address, wrapping to 0 after the limit.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc,
                                               input logic [PC_W-1:0] limit);
    if (pc == limit) return '0;
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// 2-entry FIFO of {pc, inst} between the ROM response and decode.
// Write-to-head-visible latency 1 cycle; head read is combinational.
// Caller must not push when full without a pop; flush beats push.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_inst,
  input  logic               pop,
  input  logic               flush,
  output logic               full,
  output logic               empty,
  output logic [1:0]         count,
  output logic [PC_W-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_inst
);

  logic [PC_W-1:0]    mem_pc   [2];
  logic [INSTR_W-1:0] mem_inst [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Empty head reads as zero so decode never sees stale words.
  assign head_pc   = empty ? '0 : mem_pc[rd_ptr];
  assign head_inst = empty ? '0 : mem_inst[rd_ptr];

  // Pointer and occupancy update; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage write; a simultaneous pop of a full queue frees the slot being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_pc[wr_ptr]   <= push_pc;
      mem_inst[wr_ptr] <= push_inst;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the 1-cycle ROM, buffers {inst, pc} for decode.
// Issue in N, ROM data in N+1, inst_valid in N+2; redirect target visible in N+3.
// Issue stalls when buffered plus in-flight words would exceed 2; data holds under !inst_ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter logic [31:0] PC_LIMIT = fetch_pkg::PC_LIMIT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam logic [2:0] DEPTH_W3 = 3'(DEPTH);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] issued_pc;
  logic            inflight;
  logic            pop;
  logic            push;
  logic            issue;
  logic [1:0]      buf_count;
  logic            buf_full;
  logic            buf_empty;
  logic [2:0]      occ_after;
  logic            unused_tgt_bits;

  assign unused_tgt_bits = ^redirect_target[1:0];

  assign inst_valid = !buf_empty;
  assign pop        = inst_valid && inst_ready;

  // Occupancy after this cycle's pop, counting the word already on its way from ROM.
  assign occ_after = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = !rst && !redirect_valid && (occ_after < DEPTH_W3);
  assign imem_en   = issue;
  assign imem_addr = fetch_pc;

  // A response landing during a redirect belongs to the old stream.
  assign push = inflight && !redirect_valid;

  fetch_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pc   (issued_pc),
    .push_inst (imem_rdata),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count),
    .head_pc   (inst_pc),
    .head_inst (inst_data)
  );

  // PC and in-flight tracking; reset beats redirect, redirect beats sequential fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight  <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_target[31:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        issued_pc <= fetch_pc;
        fetch_pc  <= next_pc(fetch_pc, PC_LIMIT);
      end
    end
  end

  // The issue rule must keep the queue from overflowing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && buf_full && !pop));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc)
  );

  // ROM contents: word i at byte address 4i, tagged so it cannot look like a pc.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  function automatic logic [31:0] seq_pc(input logic [31:0] p);
    if (p == 32'h0000_03FC) return 32'h0;
    return p + 32'd4;
  endfunction

  // Synchronous ROM with 1-cycle read latency.
  always @(posedge clk) if (imem_en) imem_rdata <= rom_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 after reset, inputs settling.
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0500;
    tick();
    tick();
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en got %b exp 0", imem_en); end
    checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", inst_data); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", inst_pc); end
    rst = 1'b0;
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL reset_first_en got %b exp 1", imem_en); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      #1;
      checks++; if (imem_en !== 1'b1 || imem_addr !== 32'(4 * c)) begin errors++; $display("FAIL stream_issue c=%0d got en=%b addr=%h exp en=1 addr=%h", c, imem_en, imem_addr, 32'(4 * c)); end
      if (c < 2) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid c=%0d got %b exp 0", c, inst_valid); end
      end else begin
        exp = 32'(4 * (c - 2));
        checks++; if (inst_valid !== 1'b1 || inst_pc !== exp || inst_data !== rom_word(exp)) begin errors++; $display("FAIL stream_out c=%0d got v=%b pc=%h d=%h exp v=1 pc=%h d=%h", c, inst_valid, inst_pc, inst_data, exp, rom_word(exp)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if (c > 0) tick();
      inst_ready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
      #1;
      if (c >= 2 && c <= 6) begin
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL bp_stall_en c=%0d got %b exp 0", c, imem_en); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== rom_word(32'h0)) begin errors++; $display("FAIL bp_hold c=%0d got v=%b pc=%h d=%h exp v=1 pc=0 d=%h", c, inst_valid, inst_pc, inst_data, rom_word(32'h0)); end
      end
      if (c == 7) begin
        checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL bp_resume_issue got en=%b addr=%h exp en=1 addr=8", imem_en, imem_addr); end
      end
      if (c >= 7) begin
        exp = 32'(4 * (c - 7));
        checks++; if (inst_valid !== 1'b1 || inst_pc !== exp) begin errors++; $display("FAIL bp_drain c=%0d got v=%b pc=%h exp v=1 pc=%h", c, inst_valid, inst_pc, exp); end
      end
    end
  endtask

  task automatic test_redirect(input logic [31:0] tgt);
    logic [31:0] exp;
    inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      redirect_valid = (c == 5);
      redirect_target = tgt;
      #1;
      if (c == 5) begin
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL redir_en tgt=%h got %b exp 0", tgt, imem_en); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC) begin errors++; $display("FAIL redir_last_old tgt=%h got v=%b pc=%h exp v=1 pc=c", tgt, inst_valid, inst_pc); end
      end
      if (c == 6) begin
        checks++; if (imem_en !== 1'b1 || imem_addr !== {tgt[31:2], 2'b00}) begin errors++; $display("FAIL redir_issue tgt=%h got en=%b addr=%h exp en=1 addr=%h", tgt, imem_en, imem_addr, {tgt[31:2], 2'b00}); end
      end
      if (c == 6 || c == 7) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble tgt=%h c=%0d got %b exp 0", tgt, c, inst_valid); end
      end
      if (c == 8) exp = {tgt[31:2], 2'b00};
      if (c >= 8) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== exp || inst_data !== rom_word(exp)) begin errors++; $display("FAIL redir_stream tgt=%h c=%0d got v=%b pc=%h d=%h exp v=1 pc=%h d=%h", tgt, c, inst_valid, inst_pc, inst_data, exp, rom_word(exp)); end
        exp = seq_pc(exp);
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      redirect_valid = (c == 4 || c == 5);
      redirect_target = (c == 4) ? 32'h0000_0200 : 32'h0000_0300;
      #1;
      if (c == 4 || c == 5) begin
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL b2b_en c=%0d got %b exp 0", c, imem_en); end
      end
      if (c == 6) begin
        checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL b2b_issue got en=%b addr=%h exp en=1 addr=300", imem_en, imem_addr); end
      end
      if (c >= 5 && c <= 7) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble c=%0d got %b exp 0", c, inst_valid); end
      end
      if (c >= 8) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(32'h300 + 4 * (c - 8))) begin errors++; $display("FAIL b2b_stream c=%0d got v=%b pc=%h exp v=1 pc=%h", c, inst_valid, inst_pc, 32'(32'h300 + 4 * (c - 8))); end
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_flush_then_reset();
    inst_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) tick();
      redirect_valid = (c == 4);
      redirect_target = 32'h0000_0080;
      rst = (c == 8);
      #1;
      if (c == 3) begin
        checks++; if (imem_en !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL fr_full got en=%b v=%b pc=%h exp en=0 v=1 pc=0", imem_en, inst_valid, inst_pc); end
      end
      if (c == 5) begin
        checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h80) begin errors++; $display("FAIL fr_issue got en=%b addr=%h exp en=1 addr=80", imem_en, imem_addr); end
      end
      if (c == 5 || c == 6 || c == 9 || c == 10) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fr_bubble c=%0d got %b exp 0", c, inst_valid); end
      end
      if (c == 7) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80 || inst_data !== rom_word(32'h80)) begin errors++; $display("FAIL fr_target got v=%b pc=%h d=%h exp v=1 pc=80 d=%h", inst_valid, inst_pc, inst_data, rom_word(32'h80)); end
      end
      if (c == 8) begin
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL fr_rst_en got %b exp 0", imem_en); end
      end
      if (c == 9) begin
        checks++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL fr_rst_out got d=%h pc=%h exp 0 0", inst_data, inst_pc); end
        checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL fr_restart got en=%b addr=%h exp en=1 addr=0", imem_en, imem_addr); end
      end
      if (c >= 11) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== rom_word(32'h0)) begin errors++; $display("FAIL fr_after c=%0d got v=%b pc=%h d=%h exp v=1 pc=0 d=%h", c, inst_valid, inst_pc, inst_data, rom_word(32'h0)); end
      end
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect(32'h0000_0100);
    test_redirect(32'h0000_01FF);
    test_redirect(32'h0000_03F8);
    test_redirect(32'h0000_03FC);
    test_back_to_back();
    test_flush_then_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
